data_mem: RTL and testbench

//  Word-organised data memory for the pipelined RV32I core (MEM stage).

---
 rtl/data_mem_pkg.sv | 25 ++
 rtl/data_mem_addr_dec.sv | 38 +++
 rtl/data_mem.sv | 63 ++++++
 tb/tb_data_mem.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_pkg
//  Purpose  : Shared constants, types and helpers for the RV32I data memory.
//  Revision : 1.0  - initial release
// ============================================================================
package data_mem_pkg;

    // Default geometry of the data memory
    localparam int c_dmem_depth = 64;
    localparam int c_addr_w     = 32;
    localparam int c_data_w     = 32;

    // One memory word as seen by the MEM stage
    typedef logic [c_data_w-1:0] dmem_word_t;

    // Number of word-index bits needed to address 'depth' words
    function automatic int dmem_idx_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int c_dmem_idx_w = dmem_idx_w(c_dmem_depth);

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/data_mem_addr_dec.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_addr_dec
//  Purpose  : Splits a byte address into a word index and an in-range flag.
//             The two byte-offset bits are dropped; any set bit above the
//             index field marks the address as outside the array.
//  Revision : 1.0  - initial release
// ============================================================================
module data_mem_addr_dec
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int IDX_W  = c_dmem_idx_w
) (
    input  logic [ADDR_W-1:0] a,
    output logic [IDX_W-1:0]  idx,
    output logic              in_range
);

    // Byte offset within a word has no effect on word access
    logic [1:0] w_unused_byte_ofs;
    assign w_unused_byte_ofs = a[1:0];

    // Word index sits directly above the byte offset
    assign idx = a[IDX_W+1:2];

    // When the index field fills the whole address there are no upper bits
    // to check and every address is in range.
    generate
        if (IDX_W + 2 < ADDR_W) begin : g_upper_chk
            assign in_range = ~|a[ADDR_W-1:IDX_W+2];
        end else begin : g_no_upper
            assign in_range = 1'b1;
        end
    endgenerate

endmodule : data_mem_addr_dec
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem
//  Purpose  : Word-organised data memory for the pipelined RV32I MEM stage.
//             Synchronous write, combinational read, asynchronous clear.
//             No read-during-write forwarding: the pipeline resolves hazards.
//  Revision : 1.0  - initial release
// ============================================================================
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH  = c_dmem_depth,
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    localparam int c_idx_w = dmem_idx_w(DEPTH);

    logic [DATA_W-1:0]  r_mem [0:DEPTH-1];
    logic [c_idx_w-1:0] w_idx;
    logic               w_in_range;
    logic               w_wr_en;

    data_mem_addr_dec #(
        .ADDR_W (ADDR_W),
        .IDX_W  (c_idx_w)
    ) u_addr_dec (
        .a        (a),
        .idx      (w_idx),
        .in_range (w_in_range)
    );

    // Out-of-range writes are dropped rather than aliased onto a real word
    assign w_wr_en = we & w_in_range;

    // Array storage: asynchronous clear of every word, else clocked write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_idx] <= wd;
        end
    end

    // Combinational read; forced to zero during reset and for unmapped addresses
    always_comb begin
        rd = '0;
        if (!reset && w_in_range) begin
            rd = r_mem[w_idx];
        end
    end

endmodule : data_mem
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem
//  Purpose  : Directed self-checking bench for data_mem.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_data_mem;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;

    int n_cmp  = 0;
    int n_fail = 0;

    data_mem u_dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare read data against a hand-computed value
    task automatic check(input string tag, input logic [31:0] exp);
        n_cmp++;
        assert (rd === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, rd, exp);
        end
    endtask

    // Set address and let the combinational read settle
    task automatic rd_at(input logic [31:0] addr);
        a = addr;
        #1;
    endtask

    // One write cycle driven from the falling edge, sampled after the rising edge
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        a  = addr;
        wd = data;
        we = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        we = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        a     = 32'h0;
        wd    = 32'h0;
        #2;
        check("rd_during_reset", 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: cleared contents, including last word and unmapped address
        rd_at(32'h0);   check("rst_w0",     32'h0);
        rd_at(32'h4);   check("rst_w1",     32'h0);
        rd_at(32'hFC);  check("rst_wlast",  32'h0);
        rd_at(32'h100); check("rst_oor",    32'h0);

        // 2: write word 0; old value visible before the edge, new value after
        @(negedge clk);
        a = 32'h0; wd = 32'hDEADBEEF; we = 1'b1;
        #1;
        check("pre_edge_old", 32'h0);
        @(posedge clk);
        #1;
        check("post_edge_new", 32'hDEADBEEF);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("w0_hold", 32'hDEADBEEF);

        // 3: second word independent of the first
        wr(32'h4, 32'hCAFEBABE);
        check("w1", 32'hCAFEBABE);
        rd_at(32'h0); check("w0_intact", 32'hDEADBEEF);

        // 4: we=0 leaves the array alone; byte offset ignored
        @(negedge clk);
        a = 32'h8; wd = 32'h12345678; we = 1'b0;
        @(posedge clk);
        #1;
        check("no_we_w2", 32'h0);
        rd_at(32'h3); check("ofs3_w0", 32'hDEADBEEF);
        rd_at(32'h7); check("ofs3_w1", 32'hCAFEBABE);

        // 5: out-of-range writes are dropped, no aliasing onto low words
        wr(32'h100, 32'hFFFFFFFF);
        check("oor_rd", 32'h0);
        rd_at(32'h0); check("oor_w0_intact", 32'hDEADBEEF);
        wr(32'h8000_0004, 32'h11111111);
        check("oor_hi_rd", 32'h0);
        rd_at(32'h4); check("oor_w1_intact", 32'hCAFEBABE);

        // Last word boundary
        wr(32'hFC, 32'h0BADF00D);
        check("wlast", 32'h0BADF00D);
        rd_at(32'hFF); check("wlast_ofs", 32'h0BADF00D);

        // 6: reset between edges clears at once and blocks writes
        wr(32'hC, 32'hA5A5A5A5);
        check("w3", 32'hA5A5A5A5);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_w3", 32'h0);
        rd_at(32'h0); check("rst_async_w0", 32'h0);
        @(negedge clk);
        a = 32'hC; wd = 32'h77777777; we = 1'b1;
        @(posedge clk);
        #1;
        check("wr_blocked_in_rst", 32'h0);
        @(negedge clk);
        we    = 1'b0;
        reset = 1'b0;
        #1;
        check("post_rst_w3", 32'h0);
        rd_at(32'h4);  check("post_rst_w1",    32'h0);
        rd_at(32'hFC); check("post_rst_wlast", 32'h0);

        // First write after release is accepted normally
        wr(32'h10, 32'h5A5A5A5A);
        check("post_rst_wr", 32'h5A5A5A5A);
        rd_at(32'hC); check("post_rst_w3_still0", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_data_mem
`default_nettype wire
